// File: rtl/csr_pkg.sv
// Shared definitions for the CSR register file and its access unit:
// CSR address map, Zicsr funct3 encodings, access-unit state enum,
// the latched request payload, and an address range helper.
package csr_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned ADDR_W    = 12;
  localparam int unsigned FUNCT3_W  = 3;
  localparam int unsigned RS1_IDX_W = 5;

  // Machine information (read-only)
  localparam logic [ADDR_W-1:0] ADDRESS_MVENDORID  = 12'hF11;
  localparam logic [ADDR_W-1:0] ADDRESS_MARCHID    = 12'hF12;
  localparam logic [ADDR_W-1:0] ADDRESS_MIMPID     = 12'hF13;
  localparam logic [ADDR_W-1:0] ADDRESS_MHARTID    = 12'hF14;
  localparam logic [ADDR_W-1:0] ADDRESS_MCONFIGPTR = 12'hF15;

  // Machine trap setup / handling
  localparam logic [ADDR_W-1:0] ADDRESS_MSTATUS    = 12'h300;
  localparam logic [ADDR_W-1:0] ADDRESS_MISA       = 12'h301;
  localparam logic [ADDR_W-1:0] ADDRESS_MIE        = 12'h304;
  localparam logic [ADDR_W-1:0] ADDRESS_MTVEC      = 12'h305;
  localparam logic [ADDR_W-1:0] ADDRESS_MENVCFG    = 12'h30A;
  localparam logic [ADDR_W-1:0] ADDRESS_MSTATUSH   = 12'h310;
  localparam logic [ADDR_W-1:0] ADDRESS_MENVCFGH   = 12'h31A;
  localparam logic [ADDR_W-1:0] ADDRESS_MSCRATCH   = 12'h340;
  localparam logic [ADDR_W-1:0] ADDRESS_MEPC       = 12'h341;
  localparam logic [ADDR_W-1:0] ADDRESS_MCAUSE     = 12'h342;
  localparam logic [ADDR_W-1:0] ADDRESS_MTVAL      = 12'h343;
  localparam logic [ADDR_W-1:0] ADDRESS_MIP        = 12'h344;

  // Counters and hardware performance monitors
  localparam logic [ADDR_W-1:0] ADDRESS_MCYCLE         = 12'hB00;
  localparam logic [ADDR_W-1:0] ADDRESS_MINSTRET       = 12'hB02;
  localparam logic [ADDR_W-1:0] ADDRESS_MHPMCOUNTER3   = 12'hB03;
  localparam logic [ADDR_W-1:0] ADDRESS_MHPMCOUNTER31  = 12'hB1F;
  localparam logic [ADDR_W-1:0] ADDRESS_MCYCLEH        = 12'hB80;
  localparam logic [ADDR_W-1:0] ADDRESS_MINSTRETH      = 12'hB82;
  localparam logic [ADDR_W-1:0] ADDRESS_MHPMCOUNTER3H  = 12'hB83;
  localparam logic [ADDR_W-1:0] ADDRESS_MHPMCOUNTER31H = 12'hB9F;
  localparam logic [ADDR_W-1:0] ADDRESS_MHPMEVENT3     = 12'h323;
  localparam logic [ADDR_W-1:0] ADDRESS_MHPMEVENT31    = 12'h33F;

  // Zicsr funct3 encodings (000 and 100 are not CSR instructions)
  localparam logic [FUNCT3_W-1:0] FUNCT3_CSRRW  = 3'b001;
  localparam logic [FUNCT3_W-1:0] FUNCT3_CSRRS  = 3'b010;
  localparam logic [FUNCT3_W-1:0] FUNCT3_CSRRC  = 3'b011;
  localparam logic [FUNCT3_W-1:0] FUNCT3_CSRRWI = 3'b101;
  localparam logic [FUNCT3_W-1:0] FUNCT3_CSRRSI = 3'b110;
  localparam logic [FUNCT3_W-1:0] FUNCT3_CSRRCI = 3'b111;

  typedef enum logic [1:0] {
    STATE_IDLE  = 2'd0,
    STATE_READ  = 2'd1,
    STATE_WRITE = 2'd2,
    STATE_RESP  = 2'd3
  } state_e;

  // Request fields held for the duration of one access
  typedef struct packed {
    logic [FUNCT3_W-1:0]  funct3;
    logic [XLEN-1:0]      rs1_value;
    logic [RS1_IDX_W-1:0] rs1_field;
  } csr_req_t;

  function automatic logic address_in_range(input logic [ADDR_W-1:0] address,
                                            input logic [ADDR_W-1:0] low,
                                            input logic [ADDR_W-1:0] high);
    return (address >= low) && (address <= high);
  endfunction

endpackage

// File: rtl/csr_address_decode.sv
// Combinational CSR address decoder shared by the register file and the
// access unit.
//   address_i   : CSR address
//   legal_o     : address is implemented
//   read_only_o : address lies in the read-only quadrant (address[11:10]=11)
module csr_address_decode
  import csr_pkg::*;
#(
  parameter int unsigned HAS_COUNTERS = 1
) (
  input  logic [ADDR_W-1:0] address_i,
  output logic              legal_o,
  output logic              read_only_o
);

  // Individually named CSRs first, then the HPM counter/event ranges
  always_comb begin
    legal_o = 1'b0;
    case (address_i)
      ADDRESS_MVENDORID, ADDRESS_MARCHID, ADDRESS_MIMPID, ADDRESS_MHARTID,
      ADDRESS_MCONFIGPTR, ADDRESS_MSTATUS, ADDRESS_MISA, ADDRESS_MIE,
      ADDRESS_MTVEC, ADDRESS_MENVCFG, ADDRESS_MSTATUSH, ADDRESS_MENVCFGH,
      ADDRESS_MSCRATCH, ADDRESS_MEPC, ADDRESS_MCAUSE, ADDRESS_MTVAL,
      ADDRESS_MIP: legal_o = 1'b1;
      ADDRESS_MCYCLE, ADDRESS_MINSTRET, ADDRESS_MCYCLEH,
      ADDRESS_MINSTRETH: legal_o = (HAS_COUNTERS != 0);
      default: legal_o =
          address_in_range(address_i, ADDRESS_MHPMCOUNTER3, ADDRESS_MHPMCOUNTER31)   ||
          address_in_range(address_i, ADDRESS_MHPMCOUNTER3H, ADDRESS_MHPMCOUNTER31H) ||
          address_in_range(address_i, ADDRESS_MHPMEVENT3, ADDRESS_MHPMEVENT31);
    endcase
  end

  assign read_only_o = (address_i[ADDR_W-1 -: 2] == 2'b11);

endmodule

// File: rtl/csr_access_unit.sv
// Initiator side of the CSR access port. Runs each Zicsr instruction as a
// read / modify / write sequence against the csr register file, applies
// write suppression and illegal-access detection, and returns the old value.
//   clock, reset_n         : clock, asynchronous active-low reset
//   req_*                  : request from execute (valid/ready handshake)
//   flush                  : abort an access that has not yet written
//   csr_address            : address into csr (valid READ through RESP)
//   csr_read_value         : combinational read data from csr
//   csr_write_value/enable : one-cycle registered write strobe into csr
//   resp_*                 : old CSR value and illegal flag (valid/ready)
module csr_access_unit
  import csr_pkg::*;
#(
  parameter int unsigned HAS_COUNTERS = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [FUNCT3_W-1:0]  req_funct3,
  input  logic [ADDR_W-1:0]    req_address,
  input  logic [XLEN-1:0]      req_rs1_value,
  input  logic [RS1_IDX_W-1:0] req_rs1_field,
  input  logic                 req_rd_is_zero,
  input  logic                 flush,
  output logic [ADDR_W-1:0]    csr_address,
  input  logic [XLEN-1:0]      csr_read_value,
  output logic [XLEN-1:0]      csr_write_value,
  output logic                 csr_write_enable,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [XLEN-1:0]      resp_rd_value,
  output logic                 resp_illegal
);

  state_e            state_q, state_d;
  csr_req_t          req_q, req_d;
  logic              req_ready_q, req_ready_d;
  logic [ADDR_W-1:0] csr_address_q, csr_address_d;
  logic [XLEN-1:0]   csr_write_value_q, csr_write_value_d;
  logic              csr_write_enable_q, csr_write_enable_d;
  logic              resp_valid_q, resp_valid_d;
  logic [XLEN-1:0]   resp_rd_value_q, resp_rd_value_d;
  logic              resp_illegal_q, resp_illegal_d;

  logic              addr_legal, addr_read_only;
  logic [XLEN-1:0]   src, new_value;
  logic              do_write, illegal;

  // rd=x0 has no effect here: csr reads are side-effect free
  logic unused_rd_is_zero;
  assign unused_rd_is_zero = req_rd_is_zero;

  csr_address_decode #(
    .HAS_COUNTERS(HAS_COUNTERS)
  ) u_decode (
    .address_i  (csr_address_q),
    .legal_o    (addr_legal),
    .read_only_o(addr_read_only)
  );

  // Operand, modify and legality, evaluated against the latched request
  always_comb begin
    src = req_q.funct3[2] ? XLEN'(req_q.rs1_field) : req_q.rs1_value;
    case (req_q.funct3[1:0])
      2'b01:   new_value = src;
      2'b10:   new_value = csr_read_value | src;
      2'b11:   new_value = csr_read_value & ~src;
      default: new_value = csr_read_value;
    endcase
    // S/C forms with rs1=x0 / zimm=0 are pure reads
    do_write = (req_q.funct3[1:0] == 2'b01) || (req_q.rs1_field != '0);
    illegal  = (req_q.funct3[1:0] == 2'b00) || !addr_legal ||
               (addr_read_only && do_write);
  end

  // Next-state and next-output logic
  always_comb begin
    state_d            = state_q;
    req_d              = req_q;
    req_ready_d        = req_ready_q;
    csr_address_d      = csr_address_q;
    csr_write_value_d  = csr_write_value_q;
    csr_write_enable_d = 1'b0;
    resp_valid_d       = resp_valid_q;
    resp_rd_value_d    = resp_rd_value_q;
    resp_illegal_d     = resp_illegal_q;

    case (state_q)
      STATE_IDLE: begin
        if (req_valid && !flush) begin
          req_d.funct3    = req_funct3;
          req_d.rs1_value = req_rs1_value;
          req_d.rs1_field = req_rs1_field;
          csr_address_d   = req_address;
          req_ready_d     = 1'b0;
          state_d         = STATE_READ;
        end
      end
      STATE_READ: begin
        if (flush) begin
          req_ready_d = 1'b1;
          state_d     = STATE_IDLE;
        end else begin
          resp_rd_value_d = illegal ? '0 : csr_read_value;
          resp_illegal_d  = illegal;
          if (illegal || !do_write) begin
            resp_valid_d = 1'b1;
            state_d      = STATE_RESP;
          end else begin
            csr_write_enable_d = 1'b1;
            csr_write_value_d  = new_value;
            state_d            = STATE_WRITE;
          end
        end
      end
      STATE_WRITE: begin
        // Write is committed; flush no longer applies
        resp_valid_d = 1'b1;
        state_d      = STATE_RESP;
      end
      STATE_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
          state_d      = STATE_IDLE;
        end
      end
      default: begin
        resp_valid_d = 1'b0;
        req_ready_d  = 1'b1;
        state_d      = STATE_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q            <= STATE_IDLE;
      req_q              <= '0;
      req_ready_q        <= 1'b1;
      csr_address_q      <= '0;
      csr_write_value_q  <= '0;
      csr_write_enable_q <= 1'b0;
      resp_valid_q       <= 1'b0;
      resp_rd_value_q    <= '0;
      resp_illegal_q     <= 1'b0;
    end else begin
      state_q            <= state_d;
      req_q              <= req_d;
      req_ready_q        <= req_ready_d;
      csr_address_q      <= csr_address_d;
      csr_write_value_q  <= csr_write_value_d;
      csr_write_enable_q <= csr_write_enable_d;
      resp_valid_q       <= resp_valid_d;
      resp_rd_value_q    <= resp_rd_value_d;
      resp_illegal_q     <= resp_illegal_d;
    end
  end

  assign req_ready        = req_ready_q;
  assign csr_address      = csr_address_q;
  assign csr_write_value  = csr_write_value_q;
  assign csr_write_enable = csr_write_enable_q;
  assign resp_valid       = resp_valid_q;
  assign resp_rd_value    = resp_rd_value_q;
  assign resp_illegal     = resp_illegal_q;

endmodule

// File: tb/tb_csr_access_unit.sv
// Self-checking bench for csr_access_unit: a simple CSR storage array stands
// in for the register file; expectations come from an instruction-level model.
module tb_csr_access_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready;
  logic [2:0]  req_funct3;
  logic [11:0] req_address;
  logic [31:0] req_rs1_value;
  logic [4:0]  req_rs1_field;
  logic        req_rd_is_zero;
  logic        flush;
  logic [11:0] csr_address;
  logic [31:0] csr_read_value, csr_write_value;
  logic        csr_write_enable;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_rd_value;
  logic        resp_illegal;

  logic [31:0] csr_mem [4096];
  assign csr_read_value = csr_mem[csr_address];

  int n_checks = 0;
  int n_fail   = 0;

  csr_access_unit #(.HAS_COUNTERS(1)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_address(req_address), .req_rs1_value(req_rs1_value),
    .req_rs1_field(req_rs1_field), .req_rd_is_zero(req_rd_is_zero),
    .flush(flush), .csr_address(csr_address), .csr_read_value(csr_read_value),
    .csr_write_value(csr_write_value), .csr_write_enable(csr_write_enable),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rd_value(resp_rd_value), .resp_illegal(resp_illegal)
  );

  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  function automatic bit ref_legal(input logic [11:0] a);
    int v;
    v = int'(a);
    return v inside {'h300, 'h301, 'h304, 'h305, 'h310, 'h30A, 'h31A,
                     ['h323:'h33F], ['h340:'h344], ['hF11:'hF15],
                     ['hB03:'hB1F], ['hB83:'hB9F],
                     'hB00, 'hB02, 'hB80, 'hB82};
  endfunction

  task automatic ref_access(input logic [2:0] f3, input logic [11:0] addr,
                            input logic [31:0] rs1v, input logic [4:0] rs1f,
                            input logic [31:0] old, output bit e_ill,
                            output bit e_wr, output logic [31:0] e_new,
                            output logic [31:0] e_rd, output int e_off);
    logic [31:0] src;
    src   = f3[2] ? {27'd0, rs1f} : rs1v;
    e_wr  = (f3[1:0] == 2'b01) || (rs1f != 5'd0);
    e_ill = (f3[1:0] == 2'b00) || !ref_legal(addr) || (addr >= 12'hC00 && e_wr);
    case (f3[1:0])
      2'b01:   e_new = src;
      2'b10:   e_new = old | src;
      2'b11:   e_new = old & ~src;
      default: e_new = old;
    endcase
    if (e_ill) e_wr = 0;
    e_rd  = e_ill ? 32'd0 : old;
    e_off = e_wr ? 3 : 2;
  endtask

  // ---------------- stimulus / monitor ----------------
  // Called #1 after a rising edge with the unit idle. Offsets are cycles after
  // the acceptance cycle N (READ = 1). Writes are applied to csr_mem.
  task automatic run_access(input logic [2:0] f3, input logic [11:0] addr,
                            input logic [31:0] rs1v, input logic [4:0] rs1f,
                            input int hold, output int we_cnt, output int we_off,
                            output logic [31:0] we_val, output int resp_off,
                            output logic [31:0] rd, output logic ill,
                            output logic stable, output logic [11:0] resp_addr);
    we_cnt = 0; we_off = -1; we_val = '0; resp_off = -1;
    rd = '0; ill = 1'b0; stable = 1'b1; resp_addr = '0;
    req_valid = 1'b1; req_funct3 = f3; req_address = addr;
    req_rs1_value = rs1v; req_rs1_field = rs1f; req_rd_is_zero = 1'($urandom);
    @(posedge clock); #1;
    req_valid = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clock); #1;
      if (csr_write_enable) begin
        we_cnt++; we_off = k + 1; we_val = csr_write_value;
        csr_mem[csr_address] = csr_write_value;
      end
      if (resp_valid) begin
        resp_off = k + 1; rd = resp_rd_value; ill = resp_illegal;
        resp_addr = csr_address;
        for (int h = 0; h < hold; h++) begin
          @(posedge clock); #1;
          if (!resp_valid || resp_rd_value !== rd || resp_illegal !== ill) stable = 1'b0;
          if (csr_write_enable) we_cnt++;
        end
        resp_ready = 1'b1;
        @(posedge clock); #1;
        resp_ready = 1'b0;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    n_checks++; if (csr_write_enable !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", csr_write_enable); end
    n_checks++; if (csr_address !== 12'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 000", csr_address); end
    n_checks++; if (csr_write_value !== 32'h0) begin n_fail++; $display("FAIL reset_wval: got %h want 0", csr_write_value); end
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    n_checks++; if (resp_rd_value !== 32'h0) begin n_fail++; $display("FAIL reset_rd: got %h want 0", resp_rd_value); end
    n_checks++; if (resp_illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %b want 0", resp_illegal); end
  endtask

  task automatic test_rw_mscratch();
    int wc, wo, ro; logic [31:0] wv, rd; logic il, st; logic [11:0] ra;
    csr_mem[12'h340] = 32'h12345678;
    run_access(3'b001, 12'h340, 32'hDEADBEEF, 5'd7, 0, wc, wo, wv, ro, rd, il, st, ra);
    n_checks++; if (wc != 1 || wo != 2) begin n_fail++; $display("FAIL rw_write_timing: count %0d offset %0d want 1/2", wc, wo); end
    n_checks++; if (wv !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rw_write_value: got %h want deadbeef", wv); end
    n_checks++; if (ro != 3) begin n_fail++; $display("FAIL rw_resp_offset: got %0d want 3", ro); end
    n_checks++; if (rd !== 32'h12345678 || il !== 1'b0) begin n_fail++; $display("FAIL rw_rd: got %h ill %b want 12345678/0", rd, il); end
  endtask

  task automatic test_rs_nowrite();
    int wc, wo, ro; logic [31:0] wv, rd; logic il, st; logic [11:0] ra;
    csr_mem[12'h300] = 32'h00001800;
    run_access(3'b010, 12'h300, $urandom, 5'd0, 3, wc, wo, wv, ro, rd, il, st, ra);
    n_checks++; if (wc != 0) begin n_fail++; $display("FAIL rs_x0_nowrite: got %0d writes want 0", wc); end
    n_checks++; if (ro != 2) begin n_fail++; $display("FAIL rs_x0_resp_offset: got %0d want 2", ro); end
    n_checks++; if (rd !== 32'h1800) begin n_fail++; $display("FAIL rs_x0_rd: got %h want 1800", rd); end
    n_checks++; if (st !== 1'b1) begin n_fail++; $display("FAIL resp_hold_stable: got %b want 1", st); end
    n_checks++; if (ra !== 12'h300) begin n_fail++; $display("FAIL resp_addr_held: got %h want 300", ra); end
  endtask

  task automatic test_rci_mie();
    int wc, wo, ro; logic [31:0] wv, rd; logic il, st; logic [11:0] ra;
    csr_mem[12'h304] = 32'h888;
    run_access(3'b111, 12'h304, 32'hFFFFFFFF, 5'd8, 0, wc, wo, wv, ro, rd, il, st, ra);
    n_checks++; if (wc != 1 || wv !== 32'h880) begin n_fail++; $display("FAIL rci_write: count %0d value %h want 1/880", wc, wv); end
    n_checks++; if (rd !== 32'h888) begin n_fail++; $display("FAIL rci_rd: got %h want 888", rd); end
  endtask

  task automatic test_read_only();
    int wc, wo, ro; logic [31:0] wv, rd; logic il, st; logic [11:0] ra;
    csr_mem[12'hF14] = 32'h0;
    run_access(3'b001, 12'hF14, 32'h5, 5'd3, 0, wc, wo, wv, ro, rd, il, st, ra);
    n_checks++; if (il !== 1'b1 || wc != 0 || ro != 2) begin n_fail++; $display("FAIL rw_mhartid: ill %b writes %0d offset %0d want 1/0/2", il, wc, ro); end
    run_access(3'b010, 12'hF14, 32'h5, 5'd0, 0, wc, wo, wv, ro, rd, il, st, ra);
    n_checks++; if (il !== 1'b0 || rd !== 32'h0 || wc != 0) begin n_fail++; $display("FAIL rs_mhartid: ill %b rd %h writes %0d want 0/0/0", il, rd, wc); end
  endtask

  task automatic test_illegal();
    int wc, wo, ro; logic [31:0] wv, rd; logic il, st; logic [11:0] ra;
    csr_mem[12'h7C0] = 32'hA5A5A5A5;
    run_access(3'b001, 12'h7C0, 32'h1, 5'd1, 0, wc, wo, wv, ro, rd, il, st, ra);
    n_checks++; if (il !== 1'b1 || rd !== 32'h0 || wc != 0) begin n_fail++; $display("FAIL unknown_addr: ill %b rd %h writes %0d want 1/0/0", il, rd, wc); end
    csr_mem[12'h340] = 32'h0BADF00D;
    run_access(3'b100, 12'h340, 32'h1, 5'd1, 0, wc, wo, wv, ro, rd, il, st, ra);
    n_checks++; if (il !== 1'b1 || rd !== 32'h0 || wc != 0) begin n_fail++; $display("FAIL funct3_100: ill %b rd %h writes %0d want 1/0/0", il, rd, wc); end
  endtask

  task automatic test_flush();
    int events;
    // flush in READ
    req_valid = 1'b1; req_funct3 = 3'b001; req_address = 12'h340;
    req_rs1_value = 32'h11112222; req_rs1_field = 5'd1;
    @(posedge clock); #1;
    req_valid = 1'b0; flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0; events = 0;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL flush_read_ready: got %b want 1", req_ready); end
    for (int k = 0; k < 4; k++) begin
      if (resp_valid || csr_write_enable) events++;
      @(posedge clock); #1;
    end
    n_checks++; if (events != 0) begin n_fail++; $display("FAIL flush_read_quiet: got %0d events want 0", events); end
    // flush together with req_valid in IDLE
    req_valid = 1'b1; flush = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0; flush = 1'b0; events = 0;
    for (int k = 0; k < 4; k++) begin
      if (resp_valid || csr_write_enable || !req_ready) events++;
      @(posedge clock); #1;
    end
    n_checks++; if (events != 0) begin n_fail++; $display("FAIL flush_idle_not_accepted: got %0d events want 0", events); end
    // flush in WRITE is ignored
    csr_mem[12'h340] = 32'h00C0FFEE;
    req_valid = 1'b1; req_rs1_value = 32'h33334444;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(posedge clock); #1;
    flush = 1'b1;
    n_checks++; if (csr_write_enable !== 1'b1 || csr_write_value !== 32'h33334444) begin n_fail++; $display("FAIL flush_write_we: we %b val %h want 1/33334444", csr_write_enable, csr_write_value); end
    @(posedge clock); #1;
    flush = 1'b0;
    n_checks++; if (resp_valid !== 1'b1 || resp_rd_value !== 32'h00C0FFEE) begin n_fail++; $display("FAIL flush_write_resp: valid %b rd %h want 1/00c0ffee", resp_valid, resp_rd_value); end
    csr_mem[12'h340] = 32'h33334444;
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    int events;
    req_valid = 1'b1; req_funct3 = 3'b001; req_address = 12'h341;
    req_rs1_value = 32'h55AA55AA; req_rs1_field = 5'd2;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(posedge clock); #1;
    n_checks++; if (csr_write_enable !== 1'b1) begin n_fail++; $display("FAIL pre_reset_we: got %b want 1", csr_write_enable); end
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (csr_write_enable !== 1'b0) begin n_fail++; $display("FAIL async_reset_we: got %b want 0", csr_write_enable); end
    n_checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || csr_address !== 12'h0) begin n_fail++; $display("FAIL async_reset_state: ready %b valid %b addr %h want 1/0/000", req_ready, resp_valid, csr_address); end
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;
    events = 0;
    for (int k = 0; k < 4; k++) begin
      if (resp_valid || csr_write_enable) events++;
      @(posedge clock); #1;
    end
    n_checks++; if (events != 0) begin n_fail++; $display("FAIL reset_request_lost: got %0d events want 0", events); end
  endtask

  task automatic test_back_to_back();
    int resp_at[$]; logic rdy1, rdy3; logic [31:0] rds[$];
    csr_mem[12'h340] = 32'h600DCAFE;
    resp_ready = 1'b1;
    req_valid = 1'b1; req_funct3 = 3'b010; req_address = 12'h340;
    req_rs1_value = 32'hFFFF; req_rs1_field = 5'd0;
    rdy1 = 1'bx; rdy3 = 1'bx;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clock); #1;
      if (k == 1) rdy1 = req_ready;
      if (k == 3) rdy3 = req_ready;
      if (resp_valid) begin resp_at.push_back(k); rds.push_back(resp_rd_value); end
    end
    req_valid = 1'b0;
    repeat (4) @(posedge clock);
    #1 resp_ready = 1'b0;
    n_checks++; if (rdy1 !== 1'b0 || rdy3 !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: busy %b idle %b want 0/1", rdy1, rdy3); end
    n_checks++;
    if (resp_at.size() != 2) begin n_fail++; $display("FAIL b2b_count: got %0d responses want 2", resp_at.size()); end
    else if (resp_at[0] != 2 || resp_at[1] != 5 || rds[0] !== 32'h600DCAFE || rds[1] !== 32'h600DCAFE) begin
      n_fail++; $display("FAIL b2b_timing: offsets %0d,%0d rd %h,%h want 2,5 600dcafe", resp_at[0], resp_at[1], rds[0], rds[1]);
    end
  endtask

  task automatic test_random();
    logic [11:0] pool [24] = '{12'h300, 12'h301, 12'h304, 12'h310, 12'h340, 12'h344,
                               12'h30A, 12'h31A, 12'hF11, 12'hF15, 12'hB00, 12'hB02,
                               12'hB80, 12'hB82, 12'hB03, 12'hB1F, 12'hB9F, 12'h323,
                               12'h33F, 12'hB01, 12'hB81, 12'h322, 12'h345, 12'hC00};
    int wc, wo, ro, e_off; logic [31:0] wv, rd, e_new, e_rd, old, rs1v;
    logic il, st; logic [11:0] ra, addr; logic [2:0] f3; logic [4:0] rs1f;
    bit e_ill, e_wr;
    for (int i = 0; i < 40; i++) begin
      addr = ($urandom_range(0, 7) == 0) ? 12'($urandom) : pool[$urandom_range(0, 23)];
      f3   = 3'($urandom);
      rs1v = $urandom;
      rs1f = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      old  = $urandom;
      csr_mem[addr] = old;
      ref_access(f3, addr, rs1v, rs1f, old, e_ill, e_wr, e_new, e_rd, e_off);
      run_access(f3, addr, rs1v, rs1f, $urandom_range(0, 2), wc, wo, wv, ro, rd, il, st, ra);
      n_checks++; if (il !== e_ill || rd !== e_rd) begin n_fail++; $display("FAIL rand_resp[%0d] f3=%0d addr=%h: ill %b rd %h want %b %h", i, f3, addr, il, rd, e_ill, e_rd); end
      n_checks++; if (wc != int'(e_wr) || ro != e_off) begin n_fail++; $display("FAIL rand_timing[%0d] f3=%0d addr=%h: writes %0d resp %0d want %0d %0d", i, f3, addr, wc, ro, int'(e_wr), e_off); end
      if (e_wr) begin
        n_checks++; if (wv !== e_new || wo != 2) begin n_fail++; $display("FAIL rand_write[%0d] addr=%h: val %h off %0d want %h 2", i, addr, wv, wo, e_new); end
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_funct3 = '0; req_address = '0;
    req_rs1_value = '0; req_rs1_field = '0; req_rd_is_zero = 1'b0;
    flush = 1'b0; resp_ready = 1'b0;
    for (int a = 0; a < 4096; a++) csr_mem[a] = 32'h0;
    repeat (2) @(posedge clock);
    #1;
    test_reset();
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;
    test_rw_mscratch();
    test_rs_nowrite();
    test_rci_mie();
    test_read_only();
    test_illegal();
    test_flush();
    test_reset_mid_write();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
